// File: rtl/simplez_seq.sv
// Simplez fetch/decode/execute sequencer: drives reads toward the program memory
// and emits stores on a one-cycle strobe port.
module simplez_seq #(
    parameter logic [8:0] RESET_PC = 9'o000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic [8:0]  mem_addr,
    output logic        mem_rd,
    input  logic [11:0] mem_data,
    output logic        st_valid,
    output logic [8:0]  st_addr,
    output logic [11:0] st_data,
    output logic [11:0] acc,
    output logic [8:0]  pc,
    output logic        halted,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_OPERAND = 3'd3;
    localparam logic [2:0] S_HALTED  = 3'd4;

    localparam logic [2:0] OP_ST   = 3'd0;
    localparam logic [2:0] OP_LD   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_BR   = 3'd3;
    localparam logic [2:0] OP_BZ   = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_DEC  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    logic [2:0]  r_state;
    logic [8:0]  r_pc;
    logic [11:0] r_acc;
    logic [11:0] r_ir;
    logic        r_st_valid;
    logic [8:0]  r_st_addr;
    logic [11:0] r_st_data;
    logic        r_halted;

    logic [2:0]  w_opcode;
    logic [8:0]  w_cd;

    assign w_opcode = r_ir[11:9];
    assign w_cd     = r_ir[8:0];

    // Memory requests depend only on registered state, so they hold steady all cycle.
    assign mem_rd   = (r_state == S_FETCH) || (r_state == S_OPERAND);
    assign mem_addr = ((r_state == S_DECODE) || (r_state == S_OPERAND)) ? w_cd : r_pc;

    assign st_valid  = r_st_valid;
    assign st_addr   = r_st_addr;
    assign st_data   = r_st_data;
    assign acc       = r_acc;
    assign pc        = r_pc;
    assign halted    = r_halted;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_acc      <= 12'd0;
            r_ir       <= 12'd0;
            r_st_valid <= 1'b0;
            r_st_addr  <= 9'd0;
            r_st_data  <= 12'd0;
            r_halted   <= 1'b0;
        end else begin
            r_st_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_ir    <= mem_data;
                    r_pc    <= r_pc + 9'd1;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_state <= S_FETCH;
                    case (w_opcode)
                        OP_ST: begin
                            r_st_valid <= 1'b1;
                            r_st_addr  <= w_cd;
                            r_st_data  <= r_acc;
                        end
                        OP_LD, OP_ADD: r_state <= S_OPERAND;
                        OP_BR:  r_pc <= w_cd;
                        OP_BZ: begin
                            if (r_acc == 12'd0) r_pc <= w_cd;
                        end
                        OP_CLR: r_acc <= 12'd0;
                        OP_DEC: r_acc <= r_acc - 12'd1;
                        OP_HALT: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALTED;
                        end
                        default: r_state <= S_FETCH;
                    endcase
                end
                S_OPERAND: begin
                    r_state <= S_FETCH;
                    if (w_opcode == OP_LD) r_acc <= mem_data;
                    else                   r_acc <= r_acc + mem_data;
                end
                S_HALTED: begin
                    if (start) begin
                        r_halted <= 1'b0;
                        r_state  <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simplez_seq.sv
// Directed bench for simplez_seq with a behavioural program memory.
module tb_simplez_seq;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_OPERAND = 3'd3;
    localparam logic [2:0] S_HALTED  = 3'd4;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [8:0]  mem_addr;
    logic        mem_rd;
    logic [11:0] mem_data;
    logic        st_valid;
    logic [8:0]  st_addr;
    logic [11:0] st_data;
    logic [11:0] acc;
    logic [8:0]  pc;
    logic        halted;
    logic [2:0]  dbg_state;

    logic [11:0] mem [512];

    int n_cmp;
    int n_fail;

    simplez_seq #(.RESET_PC(9'o000)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .acc(acc), .pc(pc), .halted(halted), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers on the negedge following a read request; floats otherwise.
    always @(negedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
        else        mem_data <= 'z;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 12'o0000;
    endtask

    // Hold reset, let the caller's program be loaded, then release away from posedge.
    task automatic apply_reset();
        rstn  = 1'b0;
        start = 1'b0;
        step(1);
    endtask

    task automatic release_and_start();
        @(negedge clk);
        rstn = 1'b1;
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    int rd_cnt;
    int st_cnt;
    int halt_cyc;
    logic [8:0]  cap_addr;
    logic [11:0] cap_data;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        start  = 1'b0;
        rstn   = 1'b0;
        mem_data = 'z;
        clear_mem();
        step(2);

        // Reset values
        check("rst_state", dbg_state, S_IDLE);
        check("rst_pc", pc, 9'o000);
        check("rst_acc", acc, 12'o0000);
        check("rst_halted", halted, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_addr", mem_addr, 9'o000);
        check("rst_st_valid", st_valid, 1'b0);
        check("rst_st_addr", st_addr, 9'o000);
        check("rst_st_data", st_data, 12'o0000);

        // LD 4 / ADD 5 / ST 256 / HALT
        mem[0] = 12'o1004; mem[1] = 12'o2005; mem[2] = 12'o0400; mem[3] = 12'o7000;
        mem[4] = 12'o0004; mem[5] = 12'o0005;
        release_and_start();
        check("seq_first_fetch", dbg_state, S_FETCH);
        rd_cnt = 0; st_cnt = 0; halt_cyc = 0; cap_addr = '0; cap_data = '0;
        for (int c = 1; c <= 14; c++) begin
            if (mem_rd) rd_cnt++;
            step(1);
            if (st_valid) begin
                st_cnt++;
                cap_addr = st_addr;
                cap_data = st_data;
            end
            if (halted && halt_cyc == 0) halt_cyc = c;
        end
        check("seq_st_pulses", st_cnt, 1);
        check("seq_st_addr", cap_addr, 9'o400);
        check("seq_st_data", cap_data, 12'o0011);
        check("seq_halt_cycle", halt_cyc, 10);
        check("seq_mem_rd_cycles", rd_cnt, 6);
        check("seq_pc", pc, 9'd4);
        check("seq_acc", acc, 12'o0011);
        check("seq_state_halted", dbg_state, S_HALTED);
        check("seq_halted_mem_rd", mem_rd, 1'b0);

        // Resume from HALTED: executes mem[4] = ST 4
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("resume_halted_clear", halted, 1'b0);
        check("resume_state", dbg_state, S_FETCH);
        check("resume_mem_addr", mem_addr, 9'd4);
        step(2);
        check("resume_st_valid", st_valid, 1'b1);
        check("resume_st_addr", st_addr, 9'd4);
        check("resume_st_data", st_data, 12'o0011);
        step(1);
        check("resume_st_valid_drop", st_valid, 1'b0);

        // start ignored in FETCH/DECODE/OPERAND, plus ADD overflow
        apply_reset();
        clear_mem();
        mem[0] = 12'o1004; mem[1] = 12'o2005; mem[2] = 12'o7000;
        mem[4] = 12'o7777; mem[5] = 12'o0002;
        release_and_start();
        start = 1'b1;
        check("ign_fetch", dbg_state, S_FETCH);
        step(1);
        check("ign_decode", dbg_state, S_DECODE);
        step(1);
        check("ign_operand", dbg_state, S_OPERAND);
        check("ign_operand_addr", mem_addr, 9'd4);
        step(1);
        start = 1'b0;
        check("ign_back_fetch", dbg_state, S_FETCH);
        check("ld_acc", acc, 12'o7777);
        check("ld_pc", pc, 9'd1);
        step(3);
        check("add_wrap_acc", acc, 12'o0001);
        check("add_pc", pc, 9'd2);
        step(2);
        check("add_halted", halted, 1'b1);
        check("add_halt_pc", pc, 9'd3);

        // Zero flag and DEC wrap
        apply_reset();
        clear_mem();
        mem[0] = 12'o5000; mem[1] = 12'o4012;
        mem[10] = 12'o6000; mem[11] = 12'o4000; mem[12] = 12'o7000;
        release_and_start();
        step(2);
        check("clr_acc", acc, 12'o0000);
        step(2);
        check("bz_taken_pc", pc, 9'd10);
        check("bz_taken_addr", mem_addr, 9'd10);
        step(2);
        check("dec_wrap_acc", acc, 12'o7777);
        step(2);
        check("bz_not_taken_pc", pc, 9'd12);
        step(2);
        check("bz_halted", halted, 1'b1);
        check("bz_final_pc", pc, 9'd13);

        // PC wrap through 511
        apply_reset();
        clear_mem();
        mem[0] = 12'o3777; mem[511] = 12'o5000;
        release_and_start();
        check("wrap_pc0", pc, 9'd0);
        check("wrap_addr0", mem_addr, 9'd0);
        step(2);
        check("wrap_pc511", pc, 9'd511);
        check("wrap_addr511", mem_addr, 9'd511);
        step(1);
        check("wrap_pc_after_fetch", pc, 9'd0);
        step(1);
        check("wrap_pc0_again", pc, 9'd0);
        check("wrap_addr0_again", mem_addr, 9'd0);
        step(2);
        check("wrap_pc511_again", pc, 9'd511);
        check("wrap_addr511_again", mem_addr, 9'd511);

        // Reset in the OPERAND cycle of the second LD
        apply_reset();
        clear_mem();
        mem[0] = 12'o1004; mem[1] = 12'o1005;
        mem[4] = 12'o0123; mem[5] = 12'o0456;
        release_and_start();
        step(3);
        check("mid_first_ld", acc, 12'o0123);
        step(2);
        check("mid_in_operand", dbg_state, S_OPERAND);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid_mem_rd", mem_rd, 1'b0);
        check("mid_pc", pc, 9'o000);
        check("mid_acc", acc, 12'o0000);
        check("mid_state", dbg_state, S_IDLE);
        check("mid_st_valid", st_valid, 1'b0);
        step(1);
        @(negedge clk);
        rstn = 1'b1;
        rd_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (mem_rd) rd_cnt++;
        end
        check("mid_no_fetch", rd_cnt, 0);
        check("mid_still_idle", dbg_state, S_IDLE);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("mid_restart_fetch", mem_rd, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/simplez_seq.md
Name: simplez_seq

Overview:
- Read initiator and instruction sequencer for the Simplez 12-bit word / 9-bit address memory.
- Drives `mem_addr` and `mem_rd` toward the program memory and captures `mem_data`. The memory presents `mem_data` on the negedge after a read request.
- Fetches, decodes and executes the eight Simplez opcodes.
- Stores are emitted on a one-cycle store port, because the memory has no write path.

Parameters:
- RESET_PC, 9'o000, PC value loaded at reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rstn  input  1  reset; asynchronous, active-low.
- start  input  1  leave IDLE or HALTED and begin fetching at the current PC.
- mem_addr  output  9  memory address.
- mem_rd  output  1  memory read request.
- mem_data  input  12  memory read data; valid from the negedge following a cycle with mem_rd=1.
- st_valid  output  1  one-cycle store strobe.
- st_addr  output  9  store address.
- st_data  output  12  store data (accumulator).
- acc  output  12  accumulator A.
- pc  output  9  program counter.
- halted  output  1  high while in HALTED.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, pc=RESET_PC, acc=0, IR=0.
  - st_valid=0, st_addr=0, st_data=0, halted=0.
  - mem_rd=0, mem_addr=RESET_PC.
- Memory interface (combinational from registers, so it is stable for the whole cycle):
  - mem_rd=1 only in FETCH and OPERAND.
  - mem_addr=pc in FETCH/IDLE/HALTED; mem_addr=IR[8:0] in DECODE and OPERAND.
  - mem_data is sampled only on the posedge that ends a mem_rd=1 cycle. It is ignored otherwise (it may be Z).
- States: IDLE, FETCH, DECODE, OPERAND, HALTED.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH: at posedge, IR<=mem_data, pc<=pc+1 (mod 512, so 511 wraps to 0), -> DECODE.
- DECODE: opcode=IR[11:9], CD=IR[8:0].
  - 0 ST: st_valid<=1, st_addr<=CD, st_data<=acc -> FETCH.
  - 1 LD -> OPERAND.
  - 2 ADD -> OPERAND.
  - 3 BR: pc<=CD -> FETCH.
  - 4 BZ: if acc==0 then pc<=CD; -> FETCH.
  - 5 CLR: acc<=0 -> FETCH.
  - 6 DEC: acc<=acc-1 (mod 4096; 0 -> 12'o7777) -> FETCH.
  - 7 HALT: halted<=1 -> HALTED.
- OPERAND: at posedge, -> FETCH, and:
  - LD: acc<=mem_data.
  - ADD: acc<=acc+mem_data (mod 4096, carry discarded).
- st_valid is high exactly the one cycle after the ST DECODE posedge, and is cleared on every other cycle.
- HALTED: mem_rd=0; acc and pc hold. start=1 -> FETCH (resumes at the pc after the HALT) and clears halted.
- start in FETCH, DECODE or OPERAND is ignored.
- Timing from entering FETCH:
  - ST/BR/BZ/CLR/DEC/HALT take 2 cycles.
  - LD/ADD take 3 cycles.
- Reset asserted in any state, including OPERAND with a read outstanding, aborts immediately to the reset values. No store strobe is emitted and acc is not updated.

Test Plan:
- Sequence: mem[0]=12'o1004 (LD 4), mem[1]=12'o2005 (ADD 5), mem[2]=12'o0400 (ST 256), mem[3]=12'o7000 (HALT), mem[4]=12'o0004, mem[5]=12'o0005; one-cycle start.
  - One st_valid pulse with st_addr=9'o400, st_data=12'o0011.
  - halted rises 10 cycles after FETCH is first entered; final pc=4, acc=12'o0011.
  - mem_rd asserted in exactly 6 cycles.
- Zero flag and wrap: CLR, BZ 10, with mem[10]=DEC, mem[11]=BZ 0, mem[12]=HALT.
  - BZ is taken (pc=10).
  - DEC gives acc=12'o7777.
  - The second BZ is not taken; halted with pc=13.
- PC wrap: mem[0]=BR 511, mem[511]=CLR, then mem[0] re-executed as BR 511.
  - pc sequence observed: 0 -> 511 -> 0 (after the CLR fetch) -> 511.
  - mem_addr matches that sequence in every FETCH.
- ADD overflow: acc=12'o7777 via LD, then ADD of 12'o0002 -> acc=12'o0001.
- Reset mid-operation: assert rstn=0 at the negedge inside the OPERAND cycle of an LD.
  - Immediately: mem_rd=0, pc=RESET_PC, acc=0, state IDLE.
  - No fetch occurs until start is asserted.
- start handling:
  - start pulses during FETCH, DECODE and OPERAND change nothing.
  - start in HALTED resumes at pc=4 and executes mem[4]; halted deasserts the following cycle.
